// File: rtl/stereo_mix_pkg.sv
// -----------------------------------------------------------------------------
// stereo_mix_pkg
//
// Purpose:
//   Shared types and constants for the stereo reconstruction scheduler
//   (stereo_mix_sched) and its shared add/sub unit (stereo_alu).
//
// Contents:
//   state_t    - scheduler FSM states (fetch, left add, right sub, write)
//   alu_op_t   - operation select for the shared add/sub unit
//   DEFAULT_DATA_SIZE / DEFAULT_COUNT_SIZE - default parameter values
//   MAX_S / MIN_S - signed saturation limits for a given width, returned
//                   in a 64-bit container (callers size-cast to their width)
//
// Optional build macro: STEREO_MIX_SAT_EN (consumed by stereo_alu).
// -----------------------------------------------------------------------------
package stereo_mix_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_t;

    localparam int DEFAULT_DATA_SIZE  = 32;
    localparam int DEFAULT_COUNT_SIZE = 32;

    // Largest positive value representable in 'width' bits, two's complement.
    function automatic logic [63:0] MAX_S(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative value representable in 'width' bits. Its low 'width'
    // bits are a one followed by zeros, which is all a caller slices off.
    function automatic logic [63:0] MIN_S(input int width);
        return ~MAX_S(width);
    endfunction

endpackage

// File: rtl/stereo_alu.sv
// -----------------------------------------------------------------------------
// stereo_alu
//
// Purpose:
//   Combinational shared add/sub unit. The scheduler drives it with ADD while
//   forming the left sample and with SUB while forming the right sample.
//
// Ports:
//   a, b    in   DATA_SIZE  signed operands (a = L+R, b = L-R)
//   op      in   alu_op_t   ALU_ADD -> a + b, ALU_SUB -> a - b
//   result  out  DATA_SIZE  signed result
//
// Build option:
//   STEREO_MIX_SAT_EN defined   -> results saturate to MAX_S/MIN_S on overflow
//   STEREO_MIX_SAT_EN undefined -> results wrap modulo 2^DATA_SIZE
// -----------------------------------------------------------------------------
module stereo_alu
    import stereo_mix_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    input  alu_op_t              op,
    output logic [DATA_SIZE-1:0] result
);

    localparam int MSB = DATA_SIZE - 1;

    logic [DATA_SIZE-1:0] raw;

`ifdef STEREO_MIX_SAT_EN
    localparam logic [DATA_SIZE-1:0] SAT_HI = DATA_SIZE'(MAX_S(DATA_SIZE));
    localparam logic [DATA_SIZE-1:0] SAT_LO = DATA_SIZE'(MIN_S(DATA_SIZE));

    logic ovf;
`endif

    always_comb begin
        raw = (op == ALU_SUB) ? (a - b) : (a + b);
`ifdef STEREO_MIX_SAT_EN
        // Overflow from sign bits only: an add overflows when both operands
        // share a sign the result lacks; a subtract overflows when the
        // operands differ in sign and the result's sign differs from a.
        if (op == ALU_SUB) begin
            ovf = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
        end else begin
            ovf = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
        end
        // In both overflow cases the true result has the sign of a.
        if (ovf) begin
            result = a[MSB] ? SAT_LO : SAT_HI;
        end else begin
            result = raw;
        end
`else
        result = raw;
`endif
    end

endmodule

// File: rtl/stereo_mix_sched.sv
// -----------------------------------------------------------------------------
// stereo_mix_sched
//
// Purpose:
//   Stereo reconstruction scheduler. Pops one L+R sample and one L-R sample
//   together, then reuses a single add/sub unit over two cycles to form
//       left  = lpr + lmr
//       right = lpr - lmr
//   and pushes both results together. One pair is handled at a time, so the
//   peak rate is one pair every four clocks.
//
// Ports:
//   clock        in   1           rising-edge clock
//   reset        in   1           asynchronous, active-low reset
//   lpr_dout     in   DATA_SIZE   LPR FIFO head word (first-word fall-through)
//   lpr_empty    in   1           LPR FIFO empty
//   lpr_rd_en    out  1           LPR FIFO pop
//   lmr_dout     in   DATA_SIZE   LMR FIFO head word (first-word fall-through)
//   lmr_empty    in   1           LMR FIFO empty
//   lmr_rd_en    out  1           LMR FIFO pop
//   left_din     out  DATA_SIZE   left output FIFO data
//   left_full    in   1           left output FIFO full
//   left_wr_en   out  1           left output FIFO push
//   right_din    out  DATA_SIZE   right output FIFO data
//   right_full   in   1           right output FIFO full
//   right_wr_en  out  1           right output FIFO push
//   pair_count   out  COUNT_SIZE  completed left/right pushes (wraps)
//   busy         out  1           high in every state except S_FETCH
//   state_dbg    out  state_t     current FSM state, for observation only
//
// Handshake: a FIFO transfer happens on a rising edge where the matching
// rd_en/wr_en is high. rd_en is only raised when both input FIFOs are
// non-empty and wr_en only when both output FIFOs are non-full, so the two
// inputs always pop together and the two outputs always push together.
// Input pops (S_FETCH) and output pushes (S_WRITE) can never coincide.
//
// Build option: STEREO_MIX_SAT_EN selects saturating arithmetic in stereo_alu.
// -----------------------------------------------------------------------------
module stereo_mix_sched
    import stereo_mix_pkg::*;
#(
    parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
    parameter int COUNT_SIZE = DEFAULT_COUNT_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_SIZE-1:0]  lpr_dout,
    input  logic                  lpr_empty,
    output logic                  lpr_rd_en,
    input  logic [DATA_SIZE-1:0]  lmr_dout,
    input  logic                  lmr_empty,
    output logic                  lmr_rd_en,
    output logic [DATA_SIZE-1:0]  left_din,
    input  logic                  left_full,
    output logic                  left_wr_en,
    output logic [DATA_SIZE-1:0]  right_din,
    input  logic                  right_full,
    output logic                  right_wr_en,
    output logic [COUNT_SIZE-1:0] pair_count,
    output logic                  busy,
    output state_t                state_dbg
);

    state_t               state;
    state_t               state_next;
    alu_op_t              alu_op;
    logic [DATA_SIZE-1:0] alu_result;

    logic [DATA_SIZE-1:0] lpr_q;
    logic [DATA_SIZE-1:0] lmr_q;
    logic [DATA_SIZE-1:0] left_q;
    logic [DATA_SIZE-1:0] right_q;

    logic pop;
    logic push;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        lpr_rd_en   = 1'b0;
        lmr_rd_en   = 1'b0;
        left_wr_en  = 1'b0;
        right_wr_en = 1'b0;
        alu_op      = ALU_ADD;

        case (state)
            S_FETCH: begin
                lpr_rd_en = !lpr_empty && !lmr_empty;
                lmr_rd_en = !lpr_empty && !lmr_empty;
                if (!lpr_empty && !lmr_empty) begin
                    state_next = S_LEFT;
                end
            end
            S_LEFT: begin
                alu_op     = ALU_ADD;
                state_next = S_RIGHT;
            end
            S_RIGHT: begin
                alu_op     = ALU_SUB;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                left_wr_en  = !left_full && !right_full;
                right_wr_en = !left_full && !right_full;
                if (!left_full && !right_full) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign pop  = lpr_rd_en;
    assign push = left_wr_en;

    // -------------------------------------------------------------------------
    // Shared add/sub unit; operands are always the latched pair
    // -------------------------------------------------------------------------
    stereo_alu #(
        .DATA_SIZE (DATA_SIZE)
    ) u_alu (
        .a      (lpr_q),
        .b      (lmr_q),
        .op     (alu_op),
        .result (alu_result)
    );

    // -------------------------------------------------------------------------
    // Holding registers and pair counter. Everything holds while S_WRITE
    // waits on a full output FIFO, so left_din/right_din stay stable.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lpr_q      <= '0;
            lmr_q      <= '0;
            left_q     <= '0;
            right_q    <= '0;
            pair_count <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (pop) begin
                        lpr_q <= lpr_dout;
                        lmr_q <= lmr_dout;
                    end
                end
                S_LEFT: begin
                    left_q <= alu_result;
                end
                S_RIGHT: begin
                    right_q <= alu_result;
                end
                S_WRITE: begin
                    if (push) begin
                        pair_count <= pair_count + COUNT_SIZE'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign left_din  = left_q;
    assign right_din = right_q;
    assign busy      = (state != S_FETCH);
    assign state_dbg = state;

endmodule

// File: tb/tb_stereo_mix_sched.sv
// -----------------------------------------------------------------------------
// tb_stereo_mix_sched
//
// Bench for stereo_mix_sched. Input FIFOs are modelled as queues with
// first-word fall-through heads; output FIFO full flags are driven directly.
// A reference model tracks the pair in flight (expected left/right from plain
// signed arithmetic) and is compared with the DUT on every falling edge.
// Directed tests pin the model with hand-computed literal values.
// Honours STEREO_MIX_SAT_EN for the saturating build.
// -----------------------------------------------------------------------------
module tb_stereo_mix_sched;
    import stereo_mix_pkg::*;

    // ---------------------------------------------------------------- clock/reset
    logic clock;
    logic reset;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------------------------------------------------------- DUT
    logic [31:0] lpr_dout, lmr_dout, left_din, right_din, pair_count;
    logic        lpr_empty, lmr_empty, lpr_rd_en, lmr_rd_en;
    logic        left_full, right_full, left_wr_en, right_wr_en, busy;
    state_t      state_dbg;

    stereo_mix_sched #(
        .DATA_SIZE  (32),
        .COUNT_SIZE (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .lpr_dout    (lpr_dout),
        .lpr_empty   (lpr_empty),
        .lpr_rd_en   (lpr_rd_en),
        .lmr_dout    (lmr_dout),
        .lmr_empty   (lmr_empty),
        .lmr_rd_en   (lmr_rd_en),
        .left_din    (left_din),
        .left_full   (left_full),
        .left_wr_en  (left_wr_en),
        .right_din   (right_din),
        .right_full  (right_full),
        .right_wr_en (right_wr_en),
        .pair_count  (pair_count),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // ---------------------------------------------------------------- bookkeeping
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- input FIFO models
    logic [31:0] lpr_fifo[$];
    logic [31:0] lmr_fifo[$];

    task automatic refresh();
        lpr_empty = (lpr_fifo.size() == 0);
        lmr_empty = (lmr_fifo.size() == 0);
        lpr_dout  = lpr_empty ? 32'h0 : lpr_fifo[0];
        lmr_dout  = lmr_empty ? 32'h0 : lmr_fifo[0];
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        lpr_fifo.push_back(a);
        lmr_fifo.push_back(b);
        refresh();
    endtask

    // Pops take effect just after the edge that sampled rd_en.
    bit pl, pm;
    always @(posedge clock) begin
        pl = lpr_rd_en;
        pm = lmr_rd_en;
        #1;
        if (pl && lpr_fifo.size() > 0) void'(lpr_fifo.pop_front());
        if (pm && lmr_fifo.size() > 0) void'(lmr_fifo.pop_front());
        refresh();
    end

    // ---------------------------------------------------------------- reference model
    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b, input bit sub);
        longint s;
        s = sub ? (longint'($signed(a)) - longint'($signed(b)))
                : (longint'($signed(a)) + longint'($signed(b)));
`ifdef STEREO_MIX_SAT_EN
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[31:0];
    endfunction

    logic [31:0] exp_q[$];     // expected left per pair in flight
    logic [31:0] exp_r_q[$];   // expected right per pair in flight
    int          pop_cyc = 0;
    int          model_count = 0;
    int          last_latency = 0;
    logic [31:0] last_left = 0, last_right = 0;
    bit          in_flight, due, exp_rd, exp_wr;

    // A pair popped before edge N must be pushable before edge N+3 and no
    // new pop may happen while a pair is in flight.
    always @(negedge clock) begin
        if (reset) begin
            in_flight = (exp_q.size() > 0);
            due       = in_flight && (cyc - pop_cyc >= 3);
            exp_rd    = !in_flight && (lpr_fifo.size() > 0) && (lmr_fifo.size() > 0);
            exp_wr    = due && !left_full && !right_full;
            check("lpr_rd_en", lpr_rd_en, exp_rd);
            check("lmr_rd_en", lmr_rd_en, exp_rd);
            check("left_wr_en", left_wr_en, exp_wr);
            check("right_wr_en", right_wr_en, exp_wr);
            check("busy", busy, in_flight);
            check("pair_count", pair_count, 32'(model_count));
            if (due) begin
                check("left_din", left_din, exp_q[0]);
                check("right_din", right_din, exp_r_q[0]);
            end
            if (lpr_rd_en && lmr_rd_en && lpr_fifo.size() > 0 && lmr_fifo.size() > 0) begin
                exp_q.push_back(model_res(lpr_fifo[0], lmr_fifo[0], 1'b0));
                exp_r_q.push_back(model_res(lpr_fifo[0], lmr_fifo[0], 1'b1));
                pop_cyc = cyc;
            end
            if (left_wr_en && right_wr_en && exp_q.size() > 0) begin
                last_left    = left_din;
                last_right   = right_din;
                last_latency = cyc - pop_cyc;
                void'(exp_q.pop_front());
                void'(exp_r_q.pop_front());
                model_count++;
            end
        end
        cyc++;
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((lpr_fifo.size() > 0 || lmr_fifo.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain: stream still pending after %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- directed tests
    initial begin
        logic [31:0] a;
        reset      = 1'b0;
        left_full  = 1'b0;
        right_full = 1'b0;
        refresh();

        // Reset state
        repeat (3) step();
        check("rst_pair_count", pair_count, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_left_din", left_din, 32'h0);
        check("rst_right_din", right_din, 32'h0);
        check("rst_wr_en", {30'h0, left_wr_en, right_wr_en}, 32'h0);
        reset = 1'b1;
        step();

        // 1: basic pair
        push_pair(32'h0000_0010, 32'h0000_0004);
        drain(50);
        check("t1_left", last_left, 32'h0000_0014);
        check("t1_right", last_right, 32'h0000_000C);
        check("t1_count", pair_count, 32'd1);
        check("t1_latency", 32'(last_latency), 32'd3);

        // 2: stream of mixed vectors, including overflowing ones
        for (int i = 0; i < 40; i++) begin
            a = 32'(i) * 32'h1F3D_5B79;
            push_pair(a, (a ^ 32'hC3A5_0F0F) + 32'(i * 7));
        end
        drain(400);
        check("t2_count", pair_count, 32'd41);

        // 3: LMR starves while LPR holds five words
        for (int i = 0; i < 5; i++) lpr_fifo.push_back(32'(100 + i));
        refresh();
        repeat (20) step();
        check("t3_no_pop", 32'(lpr_fifo.size()), 32'd5);
        for (int i = 0; i < 5; i++) lmr_fifo.push_back(32'(i));
        refresh();
        drain(100);
        check("t3_left", last_left, 32'h0000_006C);
        check("t3_right", last_right, 32'h0000_0064);
        check("t3_count", pair_count, 32'd46);

        // 4: right output full while a pair waits to be written
        right_full = 1'b1;
        push_pair(32'd1000, 32'd1);
        push_pair(32'd2000, 32'd2);
        push_pair(32'd3000, 32'd3);
        repeat (14) step();
        check("t4_hold_left", left_din, 32'd1001);
        check("t4_hold_right", right_din, 32'd999);
        check("t4_no_push", {30'h0, left_wr_en, right_wr_en}, 32'h0);
        check("t4_no_pop", 32'(lpr_fifo.size()), 32'd2);
        right_full = 1'b0;
        drain(100);
        check("t4_count", pair_count, 32'd49);

        // 5: overflow at both ends of the range
        push_pair(32'h7FFF_FFFF, 32'h0000_0001);
        drain(50);
`ifdef STEREO_MIX_SAT_EN
        check("t5_pos_left", last_left, 32'h7FFF_FFFF);
`else
        check("t5_pos_left", last_left, 32'h8000_0000);
`endif
        check("t5_pos_right", last_right, 32'h7FFF_FFFE);
        push_pair(32'h8000_0000, 32'h0000_0001);
        drain(50);
        check("t5_neg_left", last_left, 32'h8000_0001);
`ifdef STEREO_MIX_SAT_EN
        check("t5_neg_right", last_right, 32'h8000_0000);
`else
        check("t5_neg_right", last_right, 32'h7FFF_FFFF);
`endif
        check("t5_count", pair_count, 32'd51);

        // 6: reset while the right sample is being formed
        push_pair(32'h0000_0055, 32'h0000_0011);
        for (int n = 0; n < 20 && exp_q.size() == 0; n++) step();
        step();
        reset = 1'b0;
        #1;
        exp_q.delete();
        exp_r_q.delete();
        model_count = 0;
        check("t6_left_din", left_din, 32'h0);
        check("t6_right_din", right_din, 32'h0);
        check("t6_count", pair_count, 32'h0);
        check("t6_busy", busy, 1'b0);
        check("t6_wr_en", {30'h0, left_wr_en, right_wr_en}, 32'h0);
        repeat (2) step();
        reset = 1'b1;
        step();
        push_pair(32'hFFFF_FFFB, 32'h0000_0003);
        drain(50);
        check("t6_next_left", last_left, 32'hFFFF_FFFE);
        check("t6_next_right", last_right, 32'hFFFF_FFF8);
        check("t6_next_count", pair_count, 32'd1);
        check("t6_next_latency", 32'(last_latency), 32'd3);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
